// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the execute stage.
// Holds the ALU operation and opcode enums, the pcSrc / rdSel / forwarding
// encodings, the packed EX/MEM bundle, and the immediate-extension helper.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } aluop_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B,
    OP_HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_JR  = 2'd2,
    PC_J   = 2'd3
  } pcsrc_t;

  typedef enum logic [2:0] {
    RDSEL_RD  = 3'd0,
    RDSEL_RT  = 3'd1,
    RDSEL_R31 = 3'd2
  } rdsel_t;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_WB    = 2'd2
  } fwd_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } ex_state_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store;
    logic [31:0] instr;
    logic [31:0] npc;
    logic [4:0]  wsel;
    logic        reg_wr;
    logic        d_wen;
    logic        d_ren;
    logic        jp_sel;
    logic        halt;
  } ex_mem_t;

  // Empty EX/MEM slot: no controls, no instruction.
  localparam ex_mem_t EXMEM_BUBBLE = '{
    result: 32'h0, store: 32'h0, instr: 32'h0, npc: 32'h0, wsel: 5'd0,
    reg_wr: 1'b0, d_wen: 1'b0, d_ren: 1'b0, jp_sel: 1'b0, halt: 1'b0
  };

  // Logical immediates zero-extend, LUI places imm in the upper half,
  // everything else (arith, loads/stores, branches) sign-extends.
  function automatic logic [31:0] ext_imm(input logic [5:0] op, input logic [15:0] imm);
    logic [31:0] v;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: v = {16'h0000, imm};
      OP_LUI:                   v = {imm, 16'h0000};
      default:                  v = {{16{imm[15]}}, imm};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// alu: purely combinational 32-bit ALU for the execute stage.
// Ports:
//   i_a, i_b   operands (shifts shift i_b)
//   i_shamt    shift amount from the instruction shamt field
//   i_op       operation (aluop_t)
//   o_result   32-bit wrap-around result
//   o_zero     high when o_result is zero
module alu
  import cpu_types_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [4:0]  i_shamt,
  input  aluop_t      i_op,
  output logic [31:0] o_result,
  output logic        o_zero
);

  // Operation select.
  always_comb begin
    o_result = 32'h0000_0000;
    case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_NOR:  o_result = ~(i_a | i_b);
      ALU_SLL:  o_result = i_b << i_shamt;
      ALU_SRL:  o_result = i_b >> i_shamt;
      ALU_SRA:  o_result = $signed(i_b) >>> i_shamt;
      ALU_SLT:  o_result = {31'h0, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_result = {31'h0, (i_a < i_b)};
      default:  o_result = 32'h0000_0000;
    endcase
  end

  assign o_zero = (o_result == 32'h0000_0000);

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline.
// Forwards operands, runs the ALU, resolves branches/jumps (combinational
// redirect + flush of IF/ID and ID/EX) and owns the EX/MEM register.
// After HALT enters EX/MEM the stage only loads bubbles until RST.
// Ports:
//   CLK, RST (sync, active-high)
//   ID/EX inputs: instr_i, npc_i, curr_pc_i, rdat1_i, rdat2_i, control bits,
//     aluOp_i, rdSel_i, pcSrc_i, fwdA_i, fwdB_i, wb_data_i
//   en (EX/MEM load enable), flush (bubble into EX/MEM)
//   redir_o / redir_pc_o / flush_ifid_o / flush_idex_o: control transfer
//   EX/MEM outputs: result_o, store_o, instr_o, npc_o, wsel_o, controls
//   halted_o: HALT has reached EX/MEM
module ex_stage
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] instr_i,
  input  logic [31:0] npc_i,
  input  logic [31:0] curr_pc_i,
  input  logic [31:0] rdat1_i,
  input  logic [31:0] rdat2_i,
  input  logic        regWr_i,
  input  logic        dWEN_i,
  input  logic        dREN_i,
  input  logic        jpSel_i,
  input  logic        aluSrc_i,
  input  logic        halt_i,
  input  aluop_t      aluOp_i,
  input  logic [2:0]  rdSel_i,
  input  logic [1:0]  pcSrc_i,
  input  logic [1:0]  fwdA_i,
  input  logic [1:0]  fwdB_i,
  input  logic [31:0] wb_data_i,
  input  logic        en,
  input  logic        flush,
  output logic        redir_o,
  output logic [31:0] redir_pc_o,
  output logic        flush_ifid_o,
  output logic        flush_idex_o,
  output logic [31:0] result_o,
  output logic [31:0] store_o,
  output logic [31:0] instr_o,
  output logic [31:0] npc_o,
  output logic [4:0]  wsel_o,
  output logic        regWr_o,
  output logic        dWEN_o,
  output logic        dREN_o,
  output logic        jpSel_o,
  output logic        halt_o,
  output logic        halted_o
);

  localparam ex_mem_t C_RESET = '{
    result: 32'h0, store: 32'h0, instr: 32'h0, npc: RESET_PC, wsel: 5'd0,
    reg_wr: 1'b0, d_wen: 1'b0, d_ren: 1'b0, jp_sel: 1'b0, halt: 1'b0
  };

  ex_state_t   r_state;
  ex_mem_t     r_exmem;

  ex_state_t   w_state_nxt;
  ex_mem_t     w_exmem_nxt;
  ex_mem_t     w_load;
  logic [5:0]  w_opcode;
  logic [15:0] w_imm;
  logic [31:0] w_ext_imm;
  logic [31:0] w_br_off;
  logic [31:0] w_op_a;
  logic [31:0] w_b_reg;
  logic [31:0] w_op_b;
  logic [31:0] w_alu_res;
  logic        w_zero;
  logic        w_taken;
  logic [31:0] w_target;
  logic        w_redir;
  logic [4:0]  w_wsel;
  logic        w_unused;

  assign w_opcode  = instr_i[31:26];
  assign w_imm     = instr_i[15:0];
  assign w_ext_imm = ext_imm(w_opcode, w_imm);
  assign w_br_off  = {{14{w_imm[15]}}, w_imm, 2'b00};
  // The instruction PC is carried for debug visibility only.
  assign w_unused  = ^curr_pc_i;

  // Operand A forwarding mux.
  always_comb begin
    w_op_a = rdat1_i;
    case (fwdA_i)
      FWD_REG:   w_op_a = rdat1_i;
      FWD_EXMEM: w_op_a = r_exmem.result;
      FWD_WB:    w_op_a = wb_data_i;
      default:   w_op_a = rdat1_i;
    endcase
  end

  // Operand B forwarding mux (store data comes from here, before the imm mux).
  always_comb begin
    w_b_reg = rdat2_i;
    case (fwdB_i)
      FWD_REG:   w_b_reg = rdat2_i;
      FWD_EXMEM: w_b_reg = r_exmem.result;
      FWD_WB:    w_b_reg = wb_data_i;
      default:   w_b_reg = rdat2_i;
    endcase
  end

  assign w_op_b = aluSrc_i ? w_ext_imm : w_b_reg;

  alu u_alu (
    .i_a      (w_op_a),
    .i_b      (w_op_b),
    .i_shamt  (instr_i[10:6]),
    .i_op     (aluOp_i),
    .o_result (w_alu_res),
    .o_zero   (w_zero)
  );

  // Control-transfer resolution: taken flag and target address.
  always_comb begin
    w_taken  = 1'b0;
    w_target = npc_i;
    case (pcSrc_i)
      PC_SEQ: begin
        w_taken  = 1'b0;
        w_target = npc_i;
      end
      PC_BR: begin
        w_taken  = ((w_opcode == OP_BEQ) && w_zero) || ((w_opcode == OP_BNE) && !w_zero);
        w_target = npc_i + w_br_off;
      end
      PC_JR: begin
        w_taken  = 1'b1;
        w_target = w_op_a;
      end
      PC_J: begin
        w_taken  = 1'b1;
        w_target = {npc_i[31:28], instr_i[25:0], 2'b00};
      end
      default: begin
        w_taken  = 1'b0;
        w_target = npc_i;
      end
    endcase
  end

  // A redirect only fires on the cycle the instruction actually moves on, so a
  // stalled transfer produces exactly one pulse when en returns; RST masks it.
  assign w_redir      = !RST && en && !flush && (r_state == ST_RUN) && w_taken;
  assign redir_o      = w_redir;
  assign redir_pc_o   = w_redir ? w_target : RESET_PC;
  assign flush_ifid_o = w_redir;
  assign flush_idex_o = w_redir;

  // Destination register select.
  always_comb begin
    w_wsel = instr_i[15:11];
    case (rdSel_i)
      RDSEL_RD:  w_wsel = instr_i[15:11];
      RDSEL_RT:  w_wsel = instr_i[20:16];
      RDSEL_R31: w_wsel = 5'd31;
      default:   w_wsel = 5'd0;
    endcase
  end

  // Bundle presented to EX/MEM on a normal load; links write PC+4.
  always_comb begin
    w_load        = EXMEM_BUBBLE;
    w_load.result = jpSel_i ? npc_i : w_alu_res;
    w_load.store  = w_b_reg;
    w_load.instr  = instr_i;
    w_load.npc    = npc_i;
    w_load.wsel   = w_wsel;
    w_load.reg_wr = regWr_i;
    w_load.d_wen  = dWEN_i;
    w_load.d_ren  = dREN_i;
    w_load.jp_sel = jpSel_i;
    w_load.halt   = halt_i;
  end

  // EX/MEM next value and halt FSM: flush > hold > (halted: bubble) > load.
  // A flushed HALT never reaches EX/MEM, so it cannot halt the stage.
  always_comb begin
    w_state_nxt = r_state;
    w_exmem_nxt = r_exmem;
    if (flush) begin
      w_exmem_nxt = EXMEM_BUBBLE;
    end else if (!en) begin
      w_exmem_nxt = r_exmem;
    end else if (r_state == ST_HALTED) begin
      w_exmem_nxt = EXMEM_BUBBLE;
    end else begin
      w_exmem_nxt = w_load;
      if (halt_i) begin
        w_state_nxt = ST_HALTED;
      end else begin
        w_state_nxt = ST_RUN;
      end
    end
  end

  // EX/MEM register and halt state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_RUN;
      r_exmem <= C_RESET;
    end else begin
      r_state <= w_state_nxt;
      r_exmem <= w_exmem_nxt;
    end
  end

  assign result_o = r_exmem.result;
  assign store_o  = r_exmem.store;
  assign instr_o  = r_exmem.instr;
  assign npc_o    = r_exmem.npc;
  assign wsel_o   = r_exmem.wsel;
  assign regWr_o  = r_exmem.reg_wr;
  assign dWEN_o   = r_exmem.d_wen;
  assign dREN_o   = r_exmem.d_ren;
  assign jpSel_o  = r_exmem.jp_sel;
  assign halt_o   = r_exmem.halt;
  assign halted_o = (r_state == ST_HALTED);

endmodule
